bridgeio_regbank_axil: RTL and testbench

//  Parametrised AXI4-Lite slave register bank; next generation of the fixed 4x32 bridgeio S00_AXI slave.

---
 rtl/bridgeio_regbank_axil_if.sv | 37 +++
 rtl/bridgeio_regbank_axil.sv | 195 +++++++++++++++++++
 tb/tb_bridgeio_regbank_axil.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridgeio_regbank_axil_if.sv
// rtl/bridgeio_regbank_axil_if.sv - AXI4-Lite bus bundle with master/slave modports
interface bridgeio_regbank_axil_if #(
    parameter int DW = 32,
    parameter int AW = 6
) ();
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/bridgeio_regbank_axil.sv
// rtl/bridgeio_regbank_axil.sv - parametrised AXI4-Lite slave register bank with RO status words
module bridgeio_regbank_axil #(
    parameter int                              C_S_AXI_DATA_WIDTH = 32,
    parameter int                              C_S_AXI_ADDR_WIDTH = 6,
    parameter int                              NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0]             RO_MASK            = '0,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0]   RESET_VALUE        = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    bridgeio_regbank_axil_if.slave                 s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_i,
    output logic [NUM_REGS-1:0]                    wr_stb
);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int SW  = DW / 8;
    localparam int LSB = $clog2(SW);
    localparam int IW  = AW - LSB;

    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_RESP = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [0:0]          wr_state_q, wr_state_d;
    logic [0:0]          rd_state_q, rd_state_d;
    logic                rdy_q, rdy_d;
    logic                aw_held_q, aw_held_d;
    logic                w_held_q, w_held_d;
    logic [IW-1:0]       aw_idx_q, aw_idx_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0] c_idx, ar_idx;
    logic [DW-1:0] c_data, rd_word;
    logic [SW-1:0] c_strb;
    logic          c_in_range, ar_in_range;
    logic          unused_ok;

    // rdy_q holds the readies low until the first edge after reset release
    assign s_axi.awready = rdy_q & (wr_state_q == WR_IDLE) & ~aw_held_q;
    assign s_axi.wready  = rdy_q & (wr_state_q == WR_IDLE) & ~w_held_q;
    assign s_axi.bvalid  = (wr_state_q == WR_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = rdy_q & (rd_state_q == RD_IDLE);
    assign s_axi.rvalid  = (rd_state_q == RD_DATA);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign wr_stb        = wr_stb_q;

    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_hs  = s_axi.wvalid & s_axi.wready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;

    // A beat arriving this cycle counts as held, so the commit lands on the later handshake edge
    assign commit     = (wr_state_q == WR_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign c_idx      = aw_held_q ? aw_idx_q : s_axi.awaddr[AW-1:LSB];
    assign c_data     = w_held_q ? wdata_q : s_axi.wdata;
    assign c_strb     = w_held_q ? wstrb_q : s_axi.wstrb;
    assign c_in_range = (32'(c_idx) < 32'(NUM_REGS));

    assign ar_idx      = s_axi.araddr[AW-1:LSB];
    assign ar_in_range = (32'(ar_idx) < 32'(NUM_REGS));

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_stb_d   = '0;
        rdy_d      = 1'b1;
        regs_d     = regs_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = s_axi.awaddr[AW-1:LSB];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi.wdata;
                    wstrb_d  = s_axi.wstrb;
                end
                if (commit) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_RESP;
                    bresp_d    = c_in_range ? RESP_OKAY : RESP_SLVERR;
                    for (int n = 0; n < NUM_REGS; n++) begin
                        // RO words swallow the write silently: OKAY, no strobe
                        if ((32'(c_idx) == 32'(n)) && !RO_MASK[n]) begin
                            wr_stb_d[n] = 1'b1;
                            for (int k = 0; k < SW; k++) begin
                                if (c_strb[k]) begin
                                    regs_d[n][8*k +: 8] = c_data[8*k +: 8];
                                end
                            end
                        end
                    end
                end
            end
            WR_RESP: begin
                if (s_axi.bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (32'(ar_idx) == 32'(n)) begin
                rd_word = RO_MASK[n] ? status_i[n*DW +: DW] : regs_q[n];
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = rd_word;
                    rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_axi.rready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            rdy_q      <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_stb_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            for (int n = 0; n < NUM_REGS; n++) begin
                regs_q[n] <= RO_MASK[n] ? '0 : RESET_VALUE;
            end
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            rdy_q      <= rdy_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_stb_q   <= wr_stb_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg_out
        assign reg_q[n*DW +: DW] = RO_MASK[n] ? '0 : regs_q[n];
    end
endmodule

// File: tb/tb_bridgeio_regbank_axil.sv
// tb/tb_bridgeio_regbank_axil.sv - self-checking bench for bridgeio_regbank_axil
module tb_bridgeio_regbank_axil;
    localparam int          NR = 16;
    localparam logic [15:0] RO = 16'h0004;
    localparam logic [31:0] RV = 32'h0000_5A5A;

    logic         clk;
    logic         rst_n;
    logic [511:0] reg_q;
    logic [511:0] status;
    logic [15:0]  wr_stb;

    logic [31:0] m_regs [NR];
    int checks;
    int errors;

    bridgeio_regbank_axil_if #(.DW(32), .AW(7)) bus ();

    bridgeio_regbank_axil #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (7),
        .NUM_REGS           (NR),
        .RO_MASK            (RO),
        .RESET_VALUE        (RV)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus.slave),
        .reg_q         (reg_q),
        .status_i      (status),
        .wr_stb        (wr_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_regq();
        logic [511:0] v;
        v = '0;
        for (int n = 0; n < NR; n++) v[n*32 +: 32] = RO[n] ? 32'h0 : m_regs[n];
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NR; n++) m_regs[n] = RV;
    endtask

    task automatic clear_drives();
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        int idx, cyc;
        logic [1:0]  exp_resp;
        logic [15:0] exp_stb;
        logic aw_done, w_done, aw_hs, w_hs;
        idx = int'(a[6:2]);
        exp_resp = 2'b00;
        exp_stb  = '0;
        if (idx >= NR) exp_resp = 2'b10;
        else if (!RO[idx]) begin
            exp_stb[idx] = 1'b1;
            for (int k = 0; k < 4; k++) if (s[k]) m_regs[idx][8*k +: 8] = d[8*k +: 8];
        end
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        while (!(aw_done && w_done) && cyc < 60) begin
            if (!aw_done && cyc >= aw_dly) bus.awvalid = 1'b1;
            if (!w_done && cyc >= w_dly) bus.wvalid = 1'b1;
            aw_hs = bus.awvalid & bus.awready;
            w_hs  = bus.wvalid & bus.wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1'b1;  bus.wvalid = 1'b0; end
            cyc++;
            if (aw_done && !w_done) begin
                chk("awready_held", bus.awready, 1'b0);
                chk("bvalid_early", bus.bvalid, 1'b0);
            end
            if (w_done && !aw_done) begin
                chk("wready_held", bus.wready, 1'b0);
                chk("bvalid_early", bus.bvalid, 1'b0);
            end
        end
        chk("aw_w_timeout", aw_done & w_done, 1'b1);
        chk("bvalid_rise", bus.bvalid, 1'b1);
        chk("bresp", bus.bresp, exp_resp);
        chk("wr_stb_pulse", wr_stb, exp_stb);
        chk("reg_q_after_write", reg_q, exp_regq());
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", bus.bvalid, 1'b1);
            chk("bresp_hold", bus.bresp, exp_resp);
            chk("awready_in_resp", bus.awready, 1'b0);
            chk("wready_in_resp", bus.wready, 1'b0);
            chk("wr_stb_one_cycle", wr_stb, 16'h0);
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        chk("bvalid_fall", bus.bvalid, 1'b0);
        chk("awready_back", bus.awready, 1'b1);
        chk("wready_back", bus.wready, 1'b1);
        chk("wr_stb_clear", wr_stb, 16'h0);
    endtask

    task automatic start_read(input logic [6:0] a, output logic [31:0] exp_d, output logic [1:0] exp_r);
        int idx, cyc;
        logic done, hs;
        idx = int'(a[6:2]);
        if (idx >= NR) begin exp_d = 32'h0; exp_r = 2'b10; end
        else begin
            exp_d = RO[idx] ? status[idx*32 +: 32] : m_regs[idx];
            exp_r = 2'b00;
        end
        bus.araddr = a; bus.arvalid = 1'b1;
        done = 1'b0; cyc = 0;
        while (!done && cyc < 60) begin
            hs = bus.arready;
            @(posedge clk); #1;
            if (hs) begin done = 1'b1; bus.arvalid = 1'b0; end
            cyc++;
        end
        chk("ar_timeout", done, 1'b1);
        chk("rvalid_rise", bus.rvalid, 1'b1);
        chk("arready_in_data", bus.arready, 1'b0);
        chk("rdata", bus.rdata, exp_d);
        chk("rresp", bus.rresp, exp_r);
    endtask

    task automatic do_read(input logic [6:0] a, input int r_dly);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        start_read(a, exp_d, exp_r);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            chk("rvalid_hold", bus.rvalid, 1'b1);
            chk("rdata_hold", bus.rdata, exp_d);
            chk("rresp_hold", bus.rresp, exp_r);
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        chk("rvalid_fall", bus.rvalid, 1'b0);
        chk("arready_back", bus.arready, 1'b1);
    endtask

    initial begin
        logic [31:0] old_w0, exp_d;
        logic [1:0]  exp_r;
        checks = 0;
        errors = 0;
        status = '0;
        clear_drives();
        model_reset();
        rst_n = 1'b0;

        // reset and release
        #203;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_reg_q", reg_q, exp_regq());
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_awready", bus.awready, 1'b1);
        chk("rst_wready", bus.wready, 1'b1);
        chk("rst_arready", bus.arready, 1'b1);
        chk("rst_wr_stb", wr_stb, 16'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_bresp", bus.bresp, 2'b00);
        chk("rst_rresp", bus.rresp, 2'b00);

        // basic writes and readback
        status[2*32 +: 32] = 32'hCAFE_0002;
        for (int i = 0; i < 4; i++) do_write(7'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
        chk("w0_const", reg_q[0 +: 32], 32'h1);
        chk("w1_const", reg_q[32 +: 32], 32'h2);
        chk("w3_const", reg_q[96 +: 32], 32'h4);
        for (int i = 0; i < 4; i++) do_read(7'(i*4), 0);

        // W three cycles ahead of AW, partial strobes
        do_write(7'h04, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(7'h04, 32'hAABB_CCDD, 4'b0101, 3, 0, 0);
        chk("strb_merge", reg_q[32 +: 32], 32'h11BB_33DD);

        // BREADY held low, then a back-to-back write
        do_write(7'h0C, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
        do_write(7'h10, 32'h1234_5678, 4'hF, 0, 1, 0);

        // zero strobe still pulses wr_stb
        do_write(7'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);

        // out of range
        do_write(7'h40, 32'h5555_5555, 4'hF, 0, 0, 0);
        do_read(7'h40, 2);

        // read-only word
        status[2*32 +: 32] = 32'hDEAD_BEEF;
        do_write(7'h08, 32'h7777_7777, 4'hF, 0, 0, 0);
        do_read(7'h08, 1);

        // read accepted on the write commit edge returns the old value
        old_w0 = m_regs[0];
        bus.awaddr = 7'h00; bus.wdata = 32'h9999_0000; bus.wstrb = 4'hF;
        bus.araddr = 7'h00;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        m_regs[0] = 32'h9999_0000;
        chk("conc_bvalid", bus.bvalid, 1'b1);
        chk("conc_rvalid", bus.rvalid, 1'b1);
        chk("conc_rdata_old", bus.rdata, old_w0);
        chk("conc_reg_q", reg_q, exp_regq());
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        chk("conc_bvalid_fall", bus.bvalid, 1'b0);
        chk("conc_rvalid_fall", bus.rvalid, 1'b0);

        // randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            logic [6:0] a;
            a = 7'($urandom_range(0, 7'h4F));
            if ($urandom_range(0, 2) != 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                status = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                do_read(a, $urandom_range(0, 2));
            end
        end

        // asynchronous reset while RVALID waits on RREADY
        status[2*32 +: 32] = 32'hDEAD_BEEF;
        start_read(7'h08, exp_d, exp_r);
        chk("pre_rst_rdata", bus.rdata, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rvalid", bus.rvalid, 1'b0);
        chk("async_rdata", bus.rdata, 32'h0);
        chk("async_reg_q", reg_q, exp_regq());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_arready", bus.arready, 1'b1);
        chk("post_rst_awready", bus.awready, 1'b1);
        chk("post_rst_rvalid", bus.rvalid, 1'b0);
        do_read(7'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
